// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sweep controller.
//   DDS_W  : tuning-word width (matches the phase accumulator)
//   DDS_DW : dwell-counter width
//   dds_state_t : sweep controller states
package dds_pkg;

    localparam int unsigned DDS_W  = 28;
    localparam int unsigned DDS_DW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        DONE = 2'd3
    } dds_state_t;

endpackage

// File: rtl/dds_sweep_ctrl_dwell_timer.sv
// Dwell down-counter for the sweep controller.
//   CLOCK_50 : clock
//   reset    : asynchronous active-low reset
//   load     : reload the counter with load_val
//   load_val : dwell value; the current word is held load_val+1 cycles
//   expire   : high (registered) while the count is 0; a single cycle
//              unless the counter is reloaded
module dds_dwell_timer
    import dds_pkg::*;
#(
    parameter int unsigned DW = DDS_DW
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          load,
    input  logic [DW-1:0] load_val,
    output logic          expire
);

    logic [DW-1:0] cnt_q;

    // expire tracks "count is zero" one register stage ahead so it is registered
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            expire <= 1'b0;
        end else if (load) begin
            cnt_q  <= load_val;
            expire <= (load_val == '0);
        end else if (cnt_q != '0) begin
            cnt_q  <= cnt_q - DW'(1);
            expire <= (cnt_q == DW'(1));
        end else begin
            expire <= 1'b0;
        end
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep controller driving the DDS tuning word M.
// Steps M from f_start to f_stop by f_step, holding each word dwell+1 cycles,
// one-shot or continuous. Optional macro SWEEP_BIDIR_EN adds a down-ramp
// (triangle sweep) after each up-ramp.
//   CLOCK_50 : clock          reset  : async active-low reset
//   start    : sweep request  abort  : terminate sweep (beats start)
//   cont     : continuous     f_start/f_stop/f_step/dwell : sweep config
//   M        : tuning word    busy   : sweep active   done : one-shot end pulse
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int unsigned W  = DDS_W,
    parameter int unsigned DW = DDS_DW
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          cont,
    input  logic [W-1:0]  f_start,
    input  logic [W-1:0]  f_stop,
    input  logic [W-1:0]  f_step,
    input  logic [DW-1:0] dwell,
    output logic [W-1:0]  M,
    output logic          busy,
    output logic          done
);

    dds_state_t    state_q;
    logic          cont_q;
    logic          final_q;
    logic [W-1:0]  start_q;
    logic [W-1:0]  stop_q;
    logic [W-1:0]  step_q;
    logic [DW-1:0] dwell_q;

    logic          expire;
    logic          load_c;
    logic [DW-1:0] load_val_c;
    logic [W:0]    up_sum_c;
    logic          up_fin_c;
    logic [W-1:0]  up_word_c;

    // Timer reloads on accepted start and on every word change
    always_comb begin
        load_c     = 1'b0;
        load_val_c = dwell_q;
        if (!abort) begin
            if (state_q == IDLE) begin
                load_c     = start;
                load_val_c = dwell;
            end else if (state_q == UP || state_q == DOWN) begin
                load_c = expire;
            end
        end
    end

    // Next up-word; the extra bit catches wrap past 2^W
    always_comb begin
        up_sum_c  = {1'b0, M} + {1'b0, step_q};
        up_fin_c  = up_sum_c[W] || (up_sum_c[W-1:0] >= stop_q);
        up_word_c = up_fin_c ? stop_q : up_sum_c[W-1:0];
    end

`ifdef SWEEP_BIDIR_EN
    logic [W:0]   dn_diff_c;
    logic         dn_fin_c;
    logic [W-1:0] dn_word_c;

    // Next down-word; the extra bit catches borrow below 0
    always_comb begin
        dn_diff_c = {1'b0, M} - {1'b0, step_q};
        dn_fin_c  = dn_diff_c[W] || (dn_diff_c[W-1:0] <= start_q);
        dn_word_c = dn_fin_c ? start_q : dn_diff_c[W-1:0];
    end
`endif

    dds_dwell_timer #(.DW(DW)) u_timer (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .load     (load_c),
        .load_val (load_val_c),
        .expire   (expire)
    );

    // Sweep FSM with registered outputs
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cont_q  <= 1'b0;
            final_q <= 1'b0;
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            M       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        cont_q  <= cont;
                        start_q <= f_start;
                        stop_q  <= f_stop;
                        step_q  <= f_step;
                        dwell_q <= dwell;
                        M       <= f_start;
                        final_q <= (f_start >= f_stop);
                        busy    <= 1'b1;
                        state_q <= UP;
                    end
                end
                UP: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        state_q <= IDLE;
                    end else if (expire) begin
                        if (!final_q) begin
                            M       <= up_word_c;
                            final_q <= up_fin_c;
`ifdef SWEEP_BIDIR_EN
                        end else if (stop_q > start_q) begin
                            // f_stop is not repeated: go straight to the first down-word
                            M       <= dn_word_c;
                            final_q <= dn_fin_c;
                            state_q <= DOWN;
`endif
                        end else if (cont_q) begin
                            M       <= start_q;
                            final_q <= (start_q >= stop_q);
                        end else begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
`ifdef SWEEP_BIDIR_EN
                DOWN: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        state_q <= IDLE;
                    end else if (expire) begin
                        if (!final_q) begin
                            M       <= dn_word_c;
                            final_q <= dn_fin_c;
                        end else if (cont_q) begin
                            // f_start is not repeated: M is f_start here, so step up from it
                            M       <= up_word_c;
                            final_q <= up_fin_c;
                            state_q <= UP;
                        end else begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
`endif
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed self-checking bench for dds_sweep_ctrl: per-cycle expected
// (M, busy, done) entries are queued with the stimulus and compared each cycle.
module tb_dds_sweep_ctrl;

    localparam int unsigned W  = 28;
    localparam int unsigned DW = 16;

    typedef struct packed {
        logic [W-1:0] m;
        logic         busy;
        logic         done;
    } exp_t;

    logic          CLOCK_50 = 1'b0;
    logic          reset    = 1'b0;
    logic          start    = 1'b0;
    logic          abort    = 1'b0;
    logic          cont     = 1'b0;
    logic [W-1:0]  f_start  = '0;
    logic [W-1:0]  f_stop   = '0;
    logic [W-1:0]  f_step   = '0;
    logic [DW-1:0] dwell    = '0;
    logic [W-1:0]  M;
    logic          busy;
    logic          done;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    dds_sweep_ctrl #(.W(W), .DW(DW)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .cont     (cont),
        .f_start  (f_start),
        .f_stop   (f_stop),
        .f_step   (f_step),
        .dwell    (dwell),
        .M        (M),
        .busy     (busy),
        .done     (done)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input exp_t e);
        n_checks++;
        assert (M === e.m) else begin
            n_fails++;
            $error("FAIL %s M observed %0h expected %0h", tag, M, e.m);
        end
        n_checks++;
        assert (busy === e.busy) else begin
            n_fails++;
            $error("FAIL %s busy observed %0b expected %0b", tag, busy, e.busy);
        end
        n_checks++;
        assert (done === e.done) else begin
            n_fails++;
            $error("FAIL %s done observed %0b expected %0b", tag, done, e.done);
        end
    endtask

    task automatic push(input logic [W-1:0] m, input logic b, input logic d, input int n);
        exp_t e;
        e.m = m; e.busy = b; e.done = d;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    // One expected entry per clock; pulse inputs are cleared after each sample
    task automatic drain(input string tag);
        exp_t e;
        int   cyc = 0;
        while (exp_q.size() > 0) begin
            @(posedge CLOCK_50);
            #1;
            start = 1'b0;
            abort = 1'b0;
            e = exp_q.pop_front();
            check($sformatf("%s[c%0d]", tag, cyc), e);
            cyc++;
        end
        @(negedge CLOCK_50);
    endtask

    task automatic cfg(input logic c, input logic [W-1:0] s, input logic [W-1:0] p,
                       input logic [W-1:0] st, input logic [DW-1:0] dw);
        cont = c; f_start = s; f_stop = p; f_step = st; dwell = dw;
    endtask

    initial begin
        exp_t e;
        // Reset state
        #25;
        e = '{m: '0, busy: 1'b0, done: 1'b0};
        check("reset", e);
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);

        // One-shot ramp 100..130 step 10, dwell 2
        cfg(1'b0, W'(100), W'(130), W'(10), DW'(2));
        start = 1'b1;
        push(W'(100), 1, 0, 3); push(W'(110), 1, 0, 3);
        push(W'(120), 1, 0, 3); push(W'(130), 1, 0, 3);
        push(W'(130), 0, 1, 1); push(W'(130), 0, 0, 2);
        drain("ramp");

        // Clamp to f_stop, dwell 0
        cfg(1'b0, W'(0), W'(25), W'(10), DW'(0));
        start = 1'b1;
        push(W'(0), 1, 0, 1); push(W'(10), 1, 0, 1);
        push(W'(20), 1, 0, 1); push(W'(25), 1, 0, 1);
        push(W'(25), 0, 1, 1); push(W'(25), 0, 0, 2);
        drain("clamp");

        // Carry out of the top bit clamps instead of wrapping
        cfg(1'b0, 28'hFFFFFF0, 28'hFFFFFFF, 28'h20, DW'(0));
        start = 1'b1;
        push(28'hFFFFFF0, 1, 0, 1); push(28'hFFFFFFF, 1, 0, 1);
        push(28'hFFFFFFF, 0, 1, 1); push(28'hFFFFFFF, 0, 0, 1);
        drain("ovf");

        // Continuous sawtooth, start-while-busy ignored, then abort during 110
        cfg(1'b1, W'(100), W'(120), W'(10), DW'(1));
        start = 1'b1;
        push(W'(100), 1, 0, 2); push(W'(110), 1, 0, 1);
        drain("cont_a");
        start = 1'b1;
        cfg(1'b0, W'(5), W'(7), W'(1), DW'(0));
        push(W'(110), 1, 0, 1); push(W'(120), 1, 0, 2);
        push(W'(100), 1, 0, 2); push(W'(110), 1, 0, 1);
        drain("cont_b");
        abort = 1'b1;
        push(W'(110), 0, 0, 3);
        drain("abort");

        // start and abort together in IDLE: abort wins
        cfg(1'b0, W'(300), W'(400), W'(10), DW'(0));
        start = 1'b1;
        abort = 1'b1;
        push(W'(110), 0, 0, 3);
        drain("prio");

        // Degenerate f_start >= f_stop: one dwell of f_start, then done
        cfg(1'b0, W'(50), W'(40), W'(5), DW'(1));
        start = 1'b1;
        push(W'(50), 1, 0, 2); push(W'(50), 0, 1, 1); push(W'(50), 0, 0, 1);
        drain("degen");

        // Zero step stalls at f_start until abort
        cfg(1'b0, W'(7), W'(9), W'(0), DW'(0));
        start = 1'b1;
        push(W'(7), 1, 0, 6);
        drain("stall");
        abort = 1'b1;
        push(W'(7), 0, 0, 1);
        drain("stall_abort");

`ifdef SWEEP_BIDIR_EN
        // Triangle one-shot 100..130..100, no repeated end words
        cfg(1'b0, W'(100), W'(130), W'(10), DW'(0));
        start = 1'b1;
        push(W'(100), 1, 0, 1); push(W'(110), 1, 0, 1); push(W'(120), 1, 0, 1);
        push(W'(130), 1, 0, 1); push(W'(120), 1, 0, 1); push(W'(110), 1, 0, 1);
        push(W'(100), 1, 0, 1); push(W'(100), 0, 1, 1); push(W'(100), 0, 0, 1);
        drain("bidir");
`endif

        // Asynchronous reset in the middle of a sweep
        cfg(1'b0, W'(200), W'(260), W'(20), DW'(3));
        start = 1'b1;
        push(W'(200), 1, 0, 4); push(W'(220), 1, 0, 1);
        drain("pre_rst");
        #3;
        reset = 1'b0;
        #1;
        e = '{m: '0, busy: 1'b0, done: 1'b0};
        check("async_rst", e);
        @(negedge CLOCK_50);
        reset = 1'b1;
        push(W'(0), 0, 0, 2);
        drain("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
